// File: rtl/dsp_mac_stream_if.sv
// Stream bundle for dsp_mac_stream: operand beats in, per-frame results out.
// The slave modport is the MAC slice; the master modport is the source/consumer side.
interface dsp_mac_stream_if #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   A;
  logic [B_WIDTH-1:0]   B;
  logic [B_WIDTH-1:0]   D;
  logic [ACC_WIDTH-1:0] C;
  logic [2:0]           OP;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] P;
  logic                 OVF;
  logic [CNT_WIDTH-1:0] BEAT_CNT;

  modport master (
    output in_valid, A, B, D, C, OP, in_last, out_ready,
    input  in_ready, out_valid, P, OVF, BEAT_CNT
  );

  modport slave (
    input  in_valid, A, B, D, C, OP, in_last, out_ready,
    output in_ready, out_valid, P, OVF, BEAT_CNT
  );
endinterface

// File: rtl/dsp_mac_stream.sv
// Four-stage pipelined pre-add / multiply / accumulate slice with frame-based
// results, optional saturation and a global stall driven by output backpressure.
module dsp_mac_stream #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int CNT_WIDTH = 8,
  parameter bit SATURATE  = 1'b1
) (
  input  logic              clk,
  input  logic              RST_N,
  dsp_mac_stream_if.slave   bus
);

  localparam int BM_WIDTH   = B_WIDTH + 1;
  localparam int PROD_WIDTH = A_WIDTH + B_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic stall;
  logic out_valid_q;

  // A pending, unaccepted result freezes the whole pipeline including S1.
  assign stall        = out_valid_q && !bus.out_ready;
  assign bus.in_ready = !stall;

  // ---------------- S1: input capture ----------------
  logic                        s1_valid_q;
  logic signed [A_WIDTH-1:0]   s1_a_q;
  logic signed [B_WIDTH-1:0]   s1_b_q;
  logic signed [B_WIDTH-1:0]   s1_d_q;
  logic signed [ACC_WIDTH-1:0] s1_c_q;
  logic [2:0]                  s1_op_q;
  logic                        s1_last_q;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_d_q     <= '0;
      s1_c_q     <= '0;
      s1_op_q    <= '0;
      s1_last_q  <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= bus.in_valid;
      s1_a_q     <= bus.A;
      s1_b_q     <= bus.B;
      s1_d_q     <= bus.D;
      s1_c_q     <= bus.C;
      s1_op_q    <= bus.OP;
      s1_last_q  <= bus.in_last;
    end
  end

  // ---------------- S2: pre-adder ----------------
  logic signed [BM_WIDTH-1:0] b_ext;
  logic signed [BM_WIDTH-1:0] d_ext;
  logic signed [BM_WIDTH-1:0] bm_d;

  always_comb begin
    b_ext = BM_WIDTH'(s1_b_q);
    d_ext = BM_WIDTH'(s1_d_q);
    bm_d  = b_ext;
    if (s1_op_q[0]) begin
      bm_d = s1_op_q[1] ? (d_ext - b_ext) : (d_ext + b_ext);
    end
  end

  logic                        s2_valid_q;
  logic signed [A_WIDTH-1:0]   s2_a_q;
  logic signed [BM_WIDTH-1:0]  s2_bm_q;
  logic signed [ACC_WIDTH-1:0] s2_c_q;
  logic                        s2_sub_q;
  logic                        s2_last_q;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_bm_q    <= '0;
      s2_c_q     <= '0;
      s2_sub_q   <= 1'b0;
      s2_last_q  <= 1'b0;
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      s2_a_q     <= s1_a_q;
      s2_bm_q    <= bm_d;
      s2_c_q     <= s1_c_q;
      s2_sub_q   <= s1_op_q[2];
      s2_last_q  <= s1_last_q;
    end
  end

  // ---------------- S3: multiplier ----------------
  logic signed [PROD_WIDTH-1:0] prod_d;

  assign prod_d = PROD_WIDTH'(s2_a_q) * PROD_WIDTH'(s2_bm_q);

  logic                        s3_valid_q;
  logic signed [ACC_WIDTH-1:0] s3_prod_q;
  logic signed [ACC_WIDTH-1:0] s3_c_q;
  logic                        s3_sub_q;
  logic                        s3_last_q;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      s3_valid_q <= 1'b0;
      s3_prod_q  <= '0;
      s3_c_q     <= '0;
      s3_sub_q   <= 1'b0;
      s3_last_q  <= 1'b0;
    end else if (!stall) begin
      s3_valid_q <= s2_valid_q;
      s3_prod_q  <= ACC_WIDTH'(prod_d);
      s3_c_q     <= s2_c_q;
      s3_sub_q   <= s2_sub_q;
      s3_last_q  <= s2_last_q;
    end
  end

  // ---------------- S4: accumulator and frame bookkeeping ----------------
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic                        frame_start_q;
  logic                        sticky_q;
  logic                        sticky_d;
  logic [CNT_WIDTH-1:0]        cnt_q;
  logic [CNT_WIDTH-1:0]        cnt_d;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH:0]   sum_ext;
  logic                        ovf_beat;

  always_comb begin
    base = frame_start_q ? s3_c_q : acc_q;
    if (s3_sub_q) begin
      sum_ext = (ACC_WIDTH+1)'(base) - (ACC_WIDTH+1)'(s3_prod_q);
    end else begin
      sum_ext = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(s3_prod_q);
    end
    // The extra top bit holds the true sign; disagreement with the next bit means overflow.
    ovf_beat = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
    acc_d    = sum_ext[ACC_WIDTH-1:0];
    if (ovf_beat && SATURATE) begin
      acc_d = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    sticky_d = (frame_start_q ? 1'b0 : sticky_q) | ovf_beat;
    if (frame_start_q) begin
      cnt_d = CNT_WIDTH'(1);
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  logic [ACC_WIDTH-1:0] p_q;
  logic                 ovf_q;
  logic [CNT_WIDTH-1:0] beat_cnt_q;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      acc_q         <= '0;
      frame_start_q <= 1'b1;
      sticky_q      <= 1'b0;
      cnt_q         <= '0;
      p_q           <= '0;
      ovf_q         <= 1'b0;
      beat_cnt_q    <= '0;
      out_valid_q   <= 1'b0;
    end else if (!stall) begin
      if (s3_valid_q) begin
        acc_q         <= acc_d;
        sticky_q      <= sticky_d;
        cnt_q         <= cnt_d;
        frame_start_q <= s3_last_q;
      end
      // Not stalled means any held result is being taken now, so a new last beat may replace it.
      if (s3_valid_q && s3_last_q) begin
        p_q         <= acc_d;
        ovf_q       <= sticky_d;
        beat_cnt_q  <= cnt_d;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.P         = p_q;
  assign bus.OVF       = ovf_q;
  assign bus.BEAT_CNT  = beat_cnt_q;

endmodule
